// File: rtl/execute_muldiv_if.sv
// Operand/result channel between decode/writeback and the iterative mul/div unit.
// Valid/ready: a beat moves on a rising edge with valid && ready; once valid is raised, payload holds until that edge.
interface execute_muldiv_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, funct3, rs1, rs2, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, funct3, rs1, rs2, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/execute_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, UNROLL bits per cycle, with sign fix-up in a final cycle.
module execute_muldiv #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    output logic             busy,
    output logic [1:0]       o_state,
    execute_muldiv_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3} state_t;

    localparam int STEPS = XLEN / UNROLL;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(STEPS);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_f3;
    logic            r_neg_res;
    logic            r_neg_a;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_result;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_busy;

    logic            w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic            w_div_zero, w_ovf;
    logic [XLEN-1:0] w_a_mag, w_b_mag, w_special_res;

    // Accept-time decode: signedness, magnitudes and the results that skip iteration.
    always_comb begin
        w_is_div      = bus.funct3[2];
        w_a_signed    = w_is_div ? !bus.funct3[0] : (bus.funct3 != 3'b011);
        w_b_signed    = w_is_div ? !bus.funct3[0] : !bus.funct3[1];
        w_a_neg       = w_a_signed & bus.rs1[XLEN-1];
        w_b_neg       = w_b_signed & bus.rs2[XLEN-1];
        w_a_mag       = w_a_neg ? -bus.rs1 : bus.rs1;
        w_b_mag       = w_b_neg ? -bus.rs2 : bus.rs2;
        w_div_zero    = w_is_div && (bus.rs2 == '0);
        w_ovf         = w_is_div && !bus.funct3[0] &&
                        (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);
        w_special_res = w_div_zero ? (bus.funct3[1] ? bus.rs1 : '1)
                                   : (bus.funct3[1] ? '0 : bus.rs1);
    end

    logic [XLEN-1:0] w_hi, w_lo;
    logic [XLEN:0]   w_sh, w_diff, w_sum;

    // Divide keeps the partial remainder in hi and shifts quotient bits into lo;
    // multiply adds into hi and shifts the product down through lo.
    always_comb begin
        w_hi   = r_hi;
        w_lo   = r_lo;
        w_sh   = '0;
        w_diff = '0;
        w_sum  = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (r_f3[2]) begin
                w_sh   = {w_hi, w_lo[XLEN-1]};
                w_diff = w_sh - {1'b0, r_b};
                if (!w_diff[XLEN]) begin
                    w_hi = w_diff[XLEN-1:0];
                    w_lo = {w_lo[XLEN-2:0], 1'b1};
                end else begin
                    w_hi = w_sh[XLEN-1:0];
                    w_lo = {w_lo[XLEN-2:0], 1'b0};
                end
            end else begin
                w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_b} : '0);
                w_lo  = {w_sum[0], w_lo[XLEN-1:1]};
                w_hi  = w_sum[XLEN:1];
            end
        end
    end

    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [XLEN-1:0]   w_quo, w_rem, w_fix_res;

    always_comb begin
        w_prod    = {r_hi, r_lo};
        w_prod_s  = r_neg_res ? -w_prod : w_prod;
        w_quo     = r_neg_res ? -r_lo : r_lo;
        w_rem     = r_neg_a ? -r_hi : r_hi;
        w_fix_res = r_f3[2] ? (r_f3[1] ? w_rem : w_quo)
                            : ((r_f3[1:0] == 2'b00) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN]);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_f3        <= '0;
            r_neg_res   <= 1'b0;
            r_neg_a     <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_f3       <= bus.funct3;
                        r_neg_res  <= w_a_neg ^ w_b_neg;
                        r_neg_a    <= w_a_neg;
                        r_hi       <= '0;
                        r_lo       <= w_is_div ? w_a_mag : w_b_mag;
                        r_b        <= w_is_div ? w_b_mag : w_a_mag;
                        r_in_ready <= 1'b0;
                        if (w_div_zero || w_ovf) begin
                            r_result    <= w_special_res;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_cnt   <= CNT_INIT;
                            r_busy  <= 1'b1;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_hi <= w_hi;
                    r_lo <= w_lo;
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    r_result    <= w_fix_res;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign busy          = r_busy;
    assign o_state       = r_state;
endmodule
